// File: rtl/dmanu_st12.sv
// dmanu_st12: store-side data manipulator.
// Scatters 12 source lanes from the PE array into a 12-lane memory write word.
// Source lane i goes to destination lane tbl[i]. Entries 12..15 discard the lane.
// A per-lane write enable marks the destination lanes that were written.
// When two sources target one lane, the higher-numbered source wins.
// The output stage is registered. A one-entry skid register behind it gives
// full throughput under valid/ready.
//
// Optional feature macro: DMANU_ST_COLLIDE_CHK_EN
//   defined   : collision detection is built; o_collide is sticky and o_colcnt
//               counts collided beats, saturating at 8'hFF; i_clr clears both.
//   undefined : o_collide and o_colcnt are tied to 0, and i_clr is ignored.
//
// Ports
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready      upstream handshake
//   i_indata, i_sttbl      source lanes and store table, sampled on accept
//   i_addr                 word address, carried with the beat
//   o_valid / i_ready      downstream handshake
//   o_outdata, o_we        scattered write word and per-lane write enables
//   o_addr                 address of the output beat
//   i_clr                  clears the collision status
//   o_collide, o_colcnt    collision status

`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef ADDR_W
`define ADDR_W 8
`endif

module dmanu_st12 #(
   parameter int unsigned DATA_W = `DATA_W,
   parameter int unsigned LANES  = 12,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned ADDR_W = `ADDR_W
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [DATA_W*LANES-1:0]   i_indata,
   input  logic [SEL_W*LANES-1:0]    i_sttbl,
   input  logic [ADDR_W-1:0]         i_addr,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [DATA_W*LANES-1:0]   o_outdata,
   output logic [LANES-1:0]          o_we,
   output logic [ADDR_W-1:0]         o_addr,
   input  logic                      i_clr,
   output logic                      o_collide,
   output logic [7:0]                o_colcnt
);

   // Scatter network
   logic [DATA_W*LANES-1:0] scat_data;
   logic [LANES-1:0]        scat_we;
`ifdef DMANU_ST_COLLIDE_CHK_EN
   logic                    beat_col;
`endif

   always_comb begin
      scat_data = '0;
      scat_we   = '0;
`ifdef DMANU_ST_COLLIDE_CHK_EN
      beat_col  = 1'b0;
`endif
      for (int j = 0; j < int'(LANES); j++) begin
         // Ascending i, so a later match overwrites: the highest source wins.
         for (int i = 0; i < int'(LANES); i++) begin
            if (i_sttbl[SEL_W*i +: SEL_W] == SEL_W'(j)) begin
`ifdef DMANU_ST_COLLIDE_CHK_EN
               if (scat_we[j]) beat_col = 1'b1;
`endif
               scat_we[j]                    = 1'b1;
               scat_data[DATA_W*j +: DATA_W] = i_indata[DATA_W*i +: DATA_W];
            end
         end
      end
   end

   // Output stage plus skid register
   logic                    out_valid_q, out_valid_d;
   logic [DATA_W*LANES-1:0] out_data_q;
   logic [LANES-1:0]        out_we_q;
   logic [ADDR_W-1:0]       out_addr_q;
   logic                    skid_valid_q, skid_valid_d;
   logic [DATA_W*LANES-1:0] skid_data_q;
   logic [LANES-1:0]        skid_we_q;
   logic [ADDR_W-1:0]       skid_addr_q;

   logic accept, out_free, out_from_skid, out_from_in, skid_load;

   // o_ready comes straight from a flop. The skid can only fill while o_ready is
   // high, so no more than one beat is taken as o_ready falls.
   assign o_ready  = ~skid_valid_q;
   assign accept   = i_valid & o_ready;
   assign out_free = ~out_valid_q | i_ready;

   always_comb begin
      out_from_skid = out_free & skid_valid_q;
      out_from_in   = out_free & ~skid_valid_q & accept;
      skid_load     = accept & ~out_free;
      out_valid_d   = out_free ? (skid_valid_q | accept) : out_valid_q;
      skid_valid_d  = skid_valid_q;
      if (skid_load) begin
         skid_valid_d = 1'b1;
      end else if (out_from_skid) begin
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_we_q     <= '0;
         out_addr_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_we_q    <= '0;
         skid_addr_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         if (out_from_skid) begin
            out_data_q <= skid_data_q;
            out_we_q   <= skid_we_q;
            out_addr_q <= skid_addr_q;
         end else if (out_from_in) begin
            out_data_q <= scat_data;
            out_we_q   <= scat_we;
            out_addr_q <= i_addr;
         end
         if (skid_load) begin
            skid_data_q <= scat_data;
            skid_we_q   <= scat_we;
            skid_addr_q <= i_addr;
         end
      end
   end

   assign o_valid   = out_valid_q;
   assign o_outdata = out_data_q;
   assign o_we      = out_we_q;
   assign o_addr    = out_addr_q;

   // Collision status
`ifdef DMANU_ST_COLLIDE_CHK_EN
   logic       collide_q, collide_d;
   logic [7:0] colcnt_q, colcnt_d;
   logic       col_hit;

   assign col_hit = accept & beat_col;

   always_comb begin
      collide_d = collide_q;
      colcnt_d  = colcnt_q;
      if (i_clr) begin
         // The clear takes priority over old status but not over a collision in the same cycle.
         collide_d = col_hit;
         colcnt_d  = {7'd0, col_hit};
      end else if (col_hit) begin
         collide_d = 1'b1;
         if (colcnt_q != 8'hFF) colcnt_d = colcnt_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         collide_q <= 1'b0;
         colcnt_q  <= 8'd0;
      end else begin
         collide_q <= collide_d;
         colcnt_q  <= colcnt_d;
      end
   end

   assign o_collide = collide_q;
   assign o_colcnt  = colcnt_q;
`else
   logic unused_clr;
   assign unused_clr = i_clr;
   assign o_collide  = 1'b0;
   assign o_colcnt   = 8'd0;
`endif

endmodule

// File: tb/tb_dmanu_st12.sv
// Directed bench for dmanu_st12: scatter patterns, collisions, backpressure,
// saturation and asynchronous reset. Lane width 16, address width 8.
module tb_dmanu_st12;
   localparam int DW = 16;
   localparam int AW = 8;

   logic            clk, rst, valid_in, ready_out, ready_in, valid_out, clr, collide;
   logic [DW*12-1:0] indata, outdata;
   logic [47:0]     sttbl;
   logic [AW-1:0]   addr_in, addr_out;
   logic [11:0]     we;
   logic [7:0]      colcnt;

   int tests = 0;
   int fails = 0;

`ifdef DMANU_ST_COLLIDE_CHK_EN
   localparam bit ColEn = 1'b1;
`else
   localparam bit ColEn = 1'b0;
`endif

   localparam logic [47:0] TblId  = 48'hBA9876543210;
   localparam logic [47:0] TblRev = 48'hFFFFFF6789AB;
   localparam logic [47:0] TblCol = 48'hFFFF3FFFFFF3;

   dmanu_st12 #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready_out),
      .i_indata(indata), .i_sttbl(sttbl), .i_addr(addr_in),
      .o_valid(valid_out), .i_ready(ready_in), .o_outdata(outdata),
      .o_we(we), .o_addr(addr_out), .i_clr(clr), .o_collide(collide),
      .o_colcnt(colcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW*12-1:0] obs,
                        input logic [DW*12-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Lane i = base + i.
   function automatic logic [DW*12-1:0] mk_lanes(input logic [DW-1:0] base);
      logic [DW*12-1:0] w;
      for (int i = 0; i < 12; i++) w[DW*i +: DW] = base + DW'(i);
      return w;
   endfunction

   logic [DW*12-1:0] exp_data;
   logic [7:0]       exp_cnt;

   initial begin
      rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; clr = 1'b0;
      indata = '0; sttbl = TblId; addr_in = '0;
      #3;
      check("rst_valid", {191'd0, valid_out}, '0);
      check("rst_we", {180'd0, we}, '0);
      check("rst_data", outdata, '0);
      check("rst_addr", {184'd0, addr_out}, '0);
      check("rst_ready", {191'd0, ready_out}, 192'd1);
      check("rst_collide", {191'd0, collide}, '0);
      check("rst_colcnt", {184'd0, colcnt}, '0);
      @(negedge clk);
      rst = 1'b0;

      // Identity
      valid_in = 1'b1; indata = mk_lanes(16'd1); sttbl = TblId; addr_in = 8'h5A;
      step();
      check("id_valid", {191'd0, valid_out}, 192'd1);
      check("id_we", {180'd0, we}, {180'd0, 12'hFFF});
      check("id_data", outdata, mk_lanes(16'd1));
      check("id_addr", {184'd0, addr_out}, {184'd0, 8'h5A});

      // Reverse and discard
      indata = mk_lanes(16'h0100); sttbl = TblRev; addr_in = 8'h33;
      step();
      exp_data = '0;
      for (int i = 0; i < 6; i++) exp_data[DW*(11-i) +: DW] = 16'h0100 + 16'(i);
      check("rev_we", {180'd0, we}, {180'd0, 12'hFC0});
      check("rev_data", outdata, exp_data);
      check("rev_addr", {184'd0, addr_out}, {184'd0, 8'h33});

      // Collision: src0 and src7 to lane 3
      indata = mk_lanes(16'h0200); sttbl = TblCol; addr_in = 8'h44;
      step();
      exp_data = '0;
      exp_data[DW*3 +: DW] = 16'h0207;
      check("col_we", {180'd0, we}, {180'd0, 12'h008});
      check("col_data", outdata, exp_data);
      check("col_flag", {191'd0, collide}, {191'd0, ColEn});
      check("col_cnt", {184'd0, colcnt}, {191'd0, ColEn});
      valid_in = 1'b0;
      step();
      check("idle_valid", {191'd0, valid_out}, '0);

      // Backpressure: A, B, C back to back with the output stalled
      ready_in = 1'b0; valid_in = 1'b1; sttbl = TblId;
      indata = mk_lanes(16'h0300); addr_in = 8'hA1;
      step();
      check("bp_a_data", outdata, mk_lanes(16'h0300));
      check("bp_ready1", {191'd0, ready_out}, 192'd1);
      indata = mk_lanes(16'h0400); addr_in = 8'hA2;
      step();
      check("bp_hold_data", outdata, mk_lanes(16'h0300));
      check("bp_ready0", {191'd0, ready_out}, '0);
      indata = mk_lanes(16'h0500); addr_in = 8'hA3;
      step();
      check("bp_hold_addr", {184'd0, addr_out}, {184'd0, 8'hA1});
      check("bp_ready0b", {191'd0, ready_out}, '0);
      ready_in = 1'b1;
      step();
      check("bp_b_data", outdata, mk_lanes(16'h0400));
      check("bp_b_addr", {184'd0, addr_out}, {184'd0, 8'hA2});
      check("bp_ready_back", {191'd0, ready_out}, 192'd1);
      step();
      check("bp_c_data", outdata, mk_lanes(16'h0500));
      check("bp_c_addr", {184'd0, addr_out}, {184'd0, 8'hA3});
      check("bp_c_valid", {191'd0, valid_out}, 192'd1);
      valid_in = 1'b0;
      step();
      check("bp_drained", {191'd0, valid_out}, '0);

      // Saturation: 300 more collided beats (301 total)
      valid_in = 1'b1; sttbl = TblCol; indata = mk_lanes(16'h0600);
      for (int k = 0; k < 300; k++) step();
      valid_in = 1'b0;
      step();
      exp_cnt = ColEn ? 8'hFF : 8'h00;
      check("sat_cnt", {184'd0, colcnt}, {184'd0, exp_cnt});
      check("sat_flag", {191'd0, collide}, {191'd0, ColEn});
      clr = 1'b1;
      step();
      check("clr_cnt", {184'd0, colcnt}, '0);
      check("clr_flag", {191'd0, collide}, '0);
      // Clear and collision together
      valid_in = 1'b1;
      step();
      check("clrcol_cnt", {184'd0, colcnt}, {191'd0, ColEn});
      check("clrcol_flag", {191'd0, collide}, {191'd0, ColEn});
      clr = 1'b0; valid_in = 1'b0;
      step();

      // Reset with output and skid both full
      ready_in = 1'b0; valid_in = 1'b1; sttbl = TblId;
      indata = mk_lanes(16'h0700); addr_in = 8'hB1;
      step();
      indata = mk_lanes(16'h0800); addr_in = 8'hB2;
      step();
      check("full_ready0", {191'd0, ready_out}, '0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", {191'd0, valid_out}, '0);
      check("arst_we", {180'd0, we}, '0);
      check("arst_ready", {191'd0, ready_out}, 192'd1);
      @(negedge clk);
      rst = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      step();
      check("post_rst_valid", {191'd0, valid_out}, '0);
      step();
      check("post_rst_valid2", {191'd0, valid_out}, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
